lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Hardware sequencer for the character LCD, downstream of the memory-mapped output peripheral block. Consumes its 32-bit LCD register, turns each software write request into a timed HD44780 write cycle (RS/DATA setup, EN pulse, hold, execution wait), and runs the power-on init sequence itself, so firmware never bit-bangs EN or spins on delays.

## Interface
- POWERON_CYC, 750000: wait after reset before init (15 ms at 50 MHz).
- SETUP_CYC, 2: RS/DATA valid before EN rises.
- EN_HIGH_CYC, 25: EN high width.
- HOLD_CYC, 2: RS/DATA held after EN falls.
- EXEC_CYC, 2000: post-write wait, normal command/data (40 µs).
- CLR_EXEC_CYC, 82000: post-write wait, clear/home (1.64 ms).

- i_clk  in  1  system clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_lcd  in  32  LCD register: [31] display power, [15] request toggle, [8] RS, [7:0] data; other bits ignored.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write; constant 0.
- o_lcd_en  out  1  enable strobe.
- o_lcd_on  out  1  LCD power, registered copy of i_lcd[31].
- o_busy  out  1  transaction in progress, or init not complete.
- o_init_done  out  1  init sequence finished; stays high until reset.
- o_overflow  out  1  sticky: a request was dropped.

## Operation
- Reset is asynchronous, active-low, and may arrive mid-transaction. All outputs go to 0 immediately: o_lcd_data=0x00, rs/en/on/init_done/overflow=0. o_busy=1 while in reset and during init. The toggle history bit is 0 and the pending slot is empty.
- States: PWR_WAIT, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, EXEC_WAIT.
- PWR_WAIT: count POWERON_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD: issue ROM entries 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0. Each entry runs the full SETUP→EXEC_WAIT cycle. After the 4th entry, set o_init_done and go to IDLE.
- Request detection: a request exists when i_lcd[15] differs from the stored toggle bit. On detection, update the stored bit and capture {RS, data} from the same sample. Detection is active in every state, including during init.
- Pending slot: one entry.
  - If the FSM is in IDLE with the slot empty, the request launches directly.
  - Otherwise the request fills the empty slot.
  - If the slot is already full, the request is dropped and o_overflow is set (cleared only by reset).
- IDLE: launch the pending entry if present, else launch a new request, else stay. o_busy=0 only in IDLE with nothing to launch.
- Launch: register o_lcd_data and o_lcd_rs, then enter SETUP.
- SETUP: SETUP_CYC cycles, EN=0.
- EN_HI: EN_HIGH_CYC cycles, EN=1.
- HOLD: HOLD_CYC cycles, EN=0, data and RS unchanged.
- EXEC_WAIT: wait, then go to IDLE, or back to INIT_LOAD while init is incomplete.
  - Wait is CLR_EXEC_CYC when RS=0, data≠0, and data[7:2]=0 (clear/home commands).
  - Wait is EXEC_CYC otherwise.
- o_lcd_data and o_lcd_rs change only at launch. Outside transactions they keep the last written value.
- Counter: a single down-counter sized to $clog2(max parameter + 1). It loads (N−1) on state entry and advances state when it reaches 0. Every parameter must be ≥1.

## Timing
- o_lcd_on follows i_lcd[31] with 1 cycle of latency, independent of the FSM (0 during reset).
- Toggle edge at clock edge k, FSM in IDLE, slot empty: SETUP is entered at edge k+1, and o_busy=1 from k+1.
- EN rises after SETUP_CYC cycles in SETUP and stays high exactly EN_HIGH_CYC cycles.
- Total busy per transaction is SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + wait cycles. Back-to-back pending launch adds 1 IDLE cycle.
- A request in the same cycle as the return to IDLE is captured, not lost. If the slot is empty, it launches after the 1 IDLE cycle.
- Init duration is POWERON_CYC + 3×(S+E+H+EXEC_CYC) + (S+E+H+CLR_EXEC_CYC) + 4 INIT_LOAD cycles, where S, E, H are SETUP_CYC, EN_HIGH_CYC, HOLD_CYC.

## Test plan
All scenarios use parameters POWERON_CYC=20, SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=1, EXEC_CYC=5, CLR_EXEC_CYC=12.
- Reset, then idle: after 20 cycles, 4 EN pulses of 3 cycles each carry data 0x38, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is 12 cycles. o_init_done rises after the last wait, then o_busy=0.
- After init, write i_lcd=0x8000_8141 (toggle, RS=1, data 0x41): o_lcd_on=1 after 1 cycle; data=0x41, RS=1; EN high 3 cycles; o_busy high exactly 11 cycles.
- Command 0x01 (RS=0) gives a 12-cycle exec wait. Command 0x80 gives a 5-cycle wait.
- Three toggles during one busy transaction: the 2nd request is served next, the 3rd is dropped, o_overflow=1, and only 2 EN pulses follow.
- Toggle during init: the request is held and issued immediately after the 4th init entry.
- Assert i_rstn=0 during EN_HI: EN drops to 0 asynchronously, outputs are zero, and the full init sequence restarts after release.

Source files
------------

// File: rtl/lcd_hd44780_if.sv
// LCD register input and HD44780 pin/status outputs of the LCD sequencer.
interface lcd_hd44780_if;
  logic [31:0] i_lcd;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_init_done;
  logic        o_overflow;

  modport slave (
    input  i_lcd,
    output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on,
           o_busy, o_init_done, o_overflow
  );

  modport master (
    output i_lcd,
    input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on,
           o_busy, o_init_done, o_overflow
  );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write sequencer: power-on init, toggle-request detection with a
// one-entry pending slot, and timed SETUP/EN/HOLD/EXEC write cycles.
module lcd_hd44780_ctrl #(
  parameter int POWERON_CYC  = 750000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_HIGH_CYC  = 25,
  parameter int HOLD_CYC     = 2,
  parameter int EXEC_CYC     = 2000,
  parameter int CLR_EXEC_CYC = 82000
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  lcd_hd44780_if.slave  lcd
);

  localparam int M1   = (POWERON_CYC > CLR_EXEC_CYC) ? POWERON_CYC : CLR_EXEC_CYC;
  localparam int M2   = (EXEC_CYC > EN_HIGH_CYC) ? EXEC_CYC : EN_HIGH_CYC;
  localparam int M3   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int M12  = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M12 > M3) ? M12 : M3;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, EXEC_WAIT
  } state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_ld;
  logic [2:0]    r_idx;
  logic          r_init_done;
  logic          r_tog;
  logic          r_pend_vld, r_pend_rs;
  logic [7:0]    r_pend_data;
  logic [7:0]    r_data;
  logic          r_rs, r_on, r_ovf;
  logic          w_req, w_launch, w_ld_rs, w_clr, w_cnt_zero;
  logic [7:0]    w_ld_data;
  logic          w_unused_bits;

  assign w_req         = lcd.i_lcd[15] ^ r_tog;
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_clr         = !r_rs && (r_data != 8'h00) && (r_data[7:2] == 6'd0);
  assign w_unused_bits = ^{lcd.i_lcd[30:16], lcd.i_lcd[14:9]};

  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_ld_data = r_pend_data;
    w_ld_rs   = r_pend_rs;
    case (r_state)
      PWR_WAIT:  if (w_cnt_zero) w_next = INIT_LOAD;
      INIT_LOAD: begin
        w_launch  = 1'b1;
        w_ld_data = init_rom(r_idx[1:0]);
        w_ld_rs   = 1'b0;
        w_next    = SETUP;
      end
      IDLE: begin
        if (r_pend_vld) begin
          w_launch = 1'b1;
        end else if (w_req) begin
          w_launch  = 1'b1;
          w_ld_data = lcd.i_lcd[7:0];
          w_ld_rs   = lcd.i_lcd[8];
        end
        if (w_launch) w_next = SETUP;
      end
      SETUP:     if (w_cnt_zero) w_next = EN_HI;
      EN_HI:     if (w_cnt_zero) w_next = HOLD;
      HOLD:      if (w_cnt_zero) w_next = EXEC_WAIT;
      EXEC_WAIT: if (w_cnt_zero) w_next = r_idx[2] ? IDLE : INIT_LOAD;
      default:   w_next = PWR_WAIT;
    endcase
  end

  // Load value for the state being entered; EXEC_WAIT sees the launched data.
  always_comb begin
    w_cnt_ld = '0;
    case (w_next)
      PWR_WAIT:  w_cnt_ld = CW'(POWERON_CYC - 1);
      SETUP:     w_cnt_ld = CW'(SETUP_CYC - 1);
      EN_HI:     w_cnt_ld = CW'(EN_HIGH_CYC - 1);
      HOLD:      w_cnt_ld = CW'(HOLD_CYC - 1);
      EXEC_WAIT: w_cnt_ld = w_clr ? CW'(CLR_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
      default:   w_cnt_ld = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= CW'(POWERON_CYC - 1);
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= w_cnt_ld;
      else if (!w_cnt_zero)  r_cnt <= r_cnt - 1'b1;
      if (r_state == INIT_LOAD) r_idx <= r_idx + 3'd1;
      if (r_state == EXEC_WAIT && w_cnt_zero && r_idx[2]) r_init_done <= 1'b1;
    end
  end

  // A slot drained in IDLE can be refilled by a request arriving that same cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tog       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= 8'h00;
      r_pend_rs   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_tog <= lcd.i_lcd[15];
      if (r_state == IDLE && r_pend_vld) begin
        r_pend_vld <= w_req;
        if (w_req) begin
          r_pend_data <= lcd.i_lcd[7:0];
          r_pend_rs   <= lcd.i_lcd[8];
        end
      end else if (w_req && r_state != IDLE) begin
        if (!r_pend_vld) begin
          r_pend_vld  <= 1'b1;
          r_pend_data <= lcd.i_lcd[7:0];
          r_pend_rs   <= lcd.i_lcd[8];
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data <= 8'h00;
      r_rs   <= 1'b0;
      r_on   <= 1'b0;
    end else begin
      r_on <= lcd.i_lcd[31];
      if (w_launch) begin
        r_data <= w_ld_data;
        r_rs   <= w_ld_rs;
      end
    end
  end

  assign lcd.o_lcd_data  = r_data;
  assign lcd.o_lcd_rs    = r_rs;
  assign lcd.o_lcd_rw    = 1'b0;
  assign lcd.o_lcd_en    = (r_state == EN_HI);
  assign lcd.o_lcd_on    = r_on;
  assign lcd.o_busy      = (r_state != IDLE) || r_pend_vld;
  assign lcd.o_init_done = r_init_done;
  assign lcd.o_overflow  = r_ovf;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: expected EN pulses (data, RS, following gap) are queued
// at stimulus time and checked by a pin monitor as pulses appear.
module tb_lcd_hd44780_ctrl;
  localparam int S = 2, E = 3, H = 1, EX = 5, CLR = 12, PWR = 20;

  logic clk = 1'b0;
  logic rstn;
  lcd_hd44780_if u_if ();

  lcd_hd44780_ctrl #(
    .POWERON_CYC(PWR), .SETUP_CYC(S), .EN_HIGH_CYC(E),
    .HOLD_CYC(H), .EXEC_CYC(EX), .CLR_EXEC_CYC(CLR)
  ) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .lcd    (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, pulses = 0;
  logic tog = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    tog = ~tog;
    u_if.i_lcd = {1'b1, 15'd0, tog, 6'd0, rs, d};
  endtask

  task automatic push(input logic [7:0] d, input logic rs, input int gap);
    exp_t e;
    e.data = d; e.rs = rs; e.gap = gap;
    q.push_back(e);
  endtask

  // gap = samples after EN falls until next EN rise or busy low
  task automatic push_init(input int last_gap);
    push(8'h38, 1'b0, H + EX + 1 + S);
    push(8'h0C, 1'b0, H + EX + 1 + S);
    push(8'h01, 1'b0, H + CLR + 1 + S);
    push(8'h06, 1'b0, last_gap);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 2000 && u_if.o_busy; i++) begin
      n++;
      @(negedge clk);
    end
    if (u_if.o_busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_data", u_if.o_lcd_data, 0);
    chk("rst_rs",   u_if.o_lcd_rs, 0);
    chk("rst_rw",   u_if.o_lcd_rw, 0);
    chk("rst_en",   u_if.o_lcd_en, 0);
    chk("rst_on",   u_if.o_lcd_on, 0);
    chk("rst_done", u_if.o_init_done, 0);
    chk("rst_ovf",  u_if.o_overflow, 0);
    chk("rst_busy", u_if.o_busy, 1);
  endtask

  // Release reset and follow init; optionally inject a request mid power-wait.
  task automatic init_run(input bit with_req);
    int first_en = -1, done_cyc = -1;
    rstn = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (with_req && cyc == 5) send(1'b1, 8'h55);
      if (u_if.o_lcd_en && first_en < 0) first_en = cyc;
      if (u_if.o_init_done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("first_en_cyc", first_en, PWR + 1 + S + 1 - 1);
    chk("init_done_cyc", done_cyc, PWR + 3*(S+E+H+EX) + (S+E+H+CLR) + 4);
    chk("busy_after_init", u_if.o_busy, with_req);
  endtask

  task automatic run_one(input logic rs, input logic [7:0] d, input int gap, input int exp_busy);
    int n;
    send(rs, d);
    push(d, rs, gap);
    @(negedge clk);
    busy_len(n);
    chk("busy_len", n, exp_busy);
  endtask

  // Pin monitor
  initial begin
    bit   in_pulse = 0, in_gap = 0;
    int   w = 0, g = 0;
    exp_t cur;
    cur.data = 8'h00; cur.rs = 1'b0; cur.gap = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_pulse = 0;
        in_gap   = 0;
      end else if (u_if.o_lcd_en && !in_pulse) begin
        if (in_gap) begin
          chk("gap", g, cur.gap);
          in_gap = 0;
        end
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("pulse_data", u_if.o_lcd_data, cur.data);
          chk("pulse_rs",   u_if.o_lcd_rs, cur.rs);
        end
        pulses++;
        in_pulse = 1;
        w = 1;
      end else if (u_if.o_lcd_en) begin
        w++;
      end else if (in_pulse) begin
        chk("en_width", w, E);
        in_pulse = 0;
        in_gap   = 1;
        g = 1;
      end else if (in_gap) begin
        if (!u_if.o_busy) begin
          chk("gap", g, cur.gap);
          in_gap = 0;
        end else begin
          g++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    rstn = 1'b0;
    u_if.i_lcd = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outs();

    // Power-on init, no requests
    push_init(H + EX);
    init_run(1'b0);
    chk("on_before_write", u_if.o_lcd_on, 0);

    // Single data write 0x41 with power on
    send(1'b1, 8'h41);
    chk("i_lcd_word", u_if.i_lcd, 32'h8000_8141);
    push(8'h41, 1'b1, H + EX);
    @(negedge clk);
    chk("on_after_write", u_if.o_lcd_on, 1);
    chk("launch_data", u_if.o_lcd_data, 8'h41);
    chk("launch_rs", u_if.o_lcd_rs, 1);
    busy_len(n);
    chk("busy_len_41", n, S + E + H + EX);
    chk("data_kept", u_if.o_lcd_data, 8'h41);

    // Clear/home take the long wait; others the short one
    run_one(1'b0, 8'h01, H + CLR, S + E + H + CLR);
    run_one(1'b0, 8'h80, H + EX,  S + E + H + EX);
    run_one(1'b0, 8'h02, H + CLR, S + E + H + CLR);
    run_one(1'b0, 8'h04, H + EX,  S + E + H + EX);
    run_one(1'b1, 8'h01, H + EX,  S + E + H + EX);
    chk("ovf_clear", u_if.o_overflow, 0);

    // Three requests in one transaction: second pends, third dropped
    p0 = pulses;
    send(1'b1, 8'h61);
    push(8'h61, 1'b1, H + EX + 1 + S);
    repeat (2) @(negedge clk);
    send(1'b1, 8'h62);
    push(8'h62, 1'b1, H + EX);
    repeat (2) @(negedge clk);
    send(1'b1, 8'h63);
    @(negedge clk);
    chk("ovf_set", u_if.o_overflow, 1);
    busy_len(n);
    repeat (10) @(negedge clk);
    chk("ovf_pulses", pulses - p0, 2);
    chk("ovf_q_empty", q.size(), 0);
    chk("ovf_sticky", u_if.o_overflow, 1);

    // Reset during EN high, then a request held through init
    send(1'b1, 8'h77);
    push(8'h77, 1'b1, 0);
    for (int i = 0; i < 50 && !u_if.o_lcd_en; i++) @(negedge clk);
    chk("en_seen", u_if.o_lcd_en, 1);
    #2;
    rstn = 1'b0;
    u_if.i_lcd = 32'h0;
    tog = 1'b0;
    q.delete();
    #1;
    chk_reset_outs();
    repeat (3) @(negedge clk);
    push_init(H + EX + 1 + S);
    push(8'h55, 1'b1, H + EX);
    init_run(1'b1);
    busy_len(n);
    chk("held_req_busy", n, 1 + S + E + H + EX);
    repeat (3) @(negedge clk);
    chk("final_q_empty", q.size(), 0);
    chk("final_data", u_if.o_lcd_data, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
